fft_r22sdf_twiddle_gen: RTL
===========================

Name: fft_r22sdf_twiddle_gen

Overview:
Twiddle-factor source for one R2²SDF twiddle-multiply stage. It takes the per-sample FFT counter and produces the complex twiddle W = cos θ − j·sin θ in signed fixed point. It also emits the counter and a valid flag, delayed so that all three stay aligned. The outputs feed the stage's complex twiddle multiplier directly (the `w_re_i`/`w_im_i`/`ctr_i` side). The cosine table holds a quarter wave only; the other three quadrants are reconstructed by folding.

Parameters:
- FFT_N, 1024: full transform length; power of 4.
- NLOG2, 10: log2(FFT_N); width of the counter.
- TWIDDLE_WIDTH, 10: signed twiddle width. Full scale is 2^(TWIDDLE_WIDTH-1).
- STAGE, 0: R2² stage index s. The local block length is N_s = FFT_N >> (2·s). Valid range is 0 .. NLOG2/2−1.

Ports:
- clk_i  in  1  sample clock
- rst_n  in  1  reset, asynchronous assert, active-low
- ctr_i  in  NLOG2  sample counter n
- valid_i  in  1  ctr_i qualifies a sample this cycle
- ctr_o  out  NLOG2  ctr_i delayed 3 cycles
- valid_o  out  1  valid_i delayed 3 cycles
- w_re_o  out  TWIDDLE_WIDTH  signed twiddle real part
- w_im_o  out  TWIDDLE_WIDTH  signed twiddle imaginary part

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Assertion of rst_n low immediately clears every pipeline register. Outputs during reset are ctr_o=0, valid_o=0, w_re_o=0, w_im_o=0.
- Reset mid-stream: all in-flight samples are discarded. After release, valid_o first rises 3 cycles after the first valid_i sampled high.
- Exponent calculation:
  - k = n mod N_s; q = k / (N_s/4); m = k mod (N_s/4).
  - e_local = 0 for q=0, 2m for q=1, m for q=2, 3m for q=3.
  - e = e_local << (2·STAGE); e is always < FFT_N.
- Pipeline, latency exactly 3 cycles, throughput 1 per cycle, no stalls:
  - P1 registers e, the quadrant Q = e >> (NLOG2−2), and the residue r = e mod (FFT_N/4).
  - P2 registers the two table reads C(r) and C(FFT_N/4 − r), plus Q.
  - P3 registers the folded and signed outputs, ctr and valid.
- ctr and valid travel through 3 matching registers.
- The pipeline runs unconditionally. When valid_i=0 the outputs still update, but valid_o=0 marks them don't-care.
- Table:
  - FFT_N/4+1 entries, index i = 0..FFT_N/4.
  - C(i) = round(2^(TWIDDLE_WIDTH-1)·cos(2π·i/FFT_N)), rounding half away from zero, saturated to 2^(TWIDDLE_WIDTH-1)−1.
  - C(FFT_N/4) = 0.
  - Contents are computed at elaboration from real functions; no external file.
- Folding, as (cos θ, sin θ) per quadrant:
  - Q0: (C(r), C(N/4−r))
  - Q1: (−C(N/4−r), C(r))
  - Q2: (−C(r), −C(N/4−r))
  - Q3: (C(N/4−r), −C(r))
  - Outputs: w_re_o = cos θ, w_im_o = −sin θ.
  - Negation never overflows because magnitude ≤ 2^(TWIDDLE_WIDTH-1)−1.
- Counter wrap: ctr_i going from FFT_N−1 to 0 needs no special handling and produces no bubble.
- No internal state beyond the pipeline. The output is a pure function of the delayed ctr_i.

Test Plan (defaults, STAGE=0 unless stated):
- Reset: hold rst_n=0 while clocking random ctr_i/valid_i → all outputs 0. Drop rst_n asynchronously mid-stream → outputs go to 0 before the next clock edge.
- ctr_i=0, valid_i=1 → exactly 3 cycles later w=(511,0), ctr_o=0, valid_o=1.
- Consecutive ctr_i=256, 257, 513 → w=(511,0), (511,−6), (511,−3) on consecutive cycles.
- Wrap: stream ctr_i=1022, 1023, 0 → the ctr_o sequence repeats in order with no gap. ctr_i=1023 gives w=(−9,511); ctr_i=0 gives (511,0).
- STAGE=1: ctr_i=65 → (511,−25); ctr_i=64 → (511,0). Full sweep of 0..1023 matches a golden real-arithmetic model bit-exactly.
- valid_i pattern 1,0,1,1,0 → valid_o reproduces the same pattern 3 cycles later; data on the valid_o=1 cycles matches the golden model.

Source files
------------

// File: rtl/fft_r22sdf_twiddle_gen.sv
// rtl/fft_r22sdf_twiddle_gen.sv - R2^2 SDF stage twiddle source: counter -> folded quarter-wave cos/sin, 3-cycle pipeline
module fft_r22sdf_twiddle_gen #(
    parameter int FFT_N         = 1024,
    parameter int NLOG2         = 10,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int STAGE         = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_n,
    input  logic [NLOG2-1:0]                ctr_i,
    input  logic                            valid_i,
    output logic [NLOG2-1:0]                ctr_o,
    output logic                            valid_o,
    output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
    output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

    localparam int  QN  = FFT_N / 4;
    localparam int  FS  = 1 << (TWIDDLE_WIDTH - 1);
    localparam int  NS  = FFT_N >> (2 * STAGE);
    localparam int  QSH = NLOG2 - 2 - 2 * STAGE;
    localparam real PI  = 3.14159265358979323846;

    typedef logic signed [TWIDDLE_WIDTH-1:0] tw_t;

    tw_t cos_rom [0:QN];

    // Quarter-wave cosine, rounded half away from zero and clipped to +full-scale minus one
    for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
        localparam real ANG    = 2.0 * PI * gi / FFT_N;
        localparam real SCALED = FS * $cos(ANG);
        localparam int  RND    = (gi == QN) ? 0 : $rtoi(SCALED + 0.5);
        localparam int  SAT    = (RND > FS - 1) ? FS - 1 : RND;
        assign cos_rom[gi] = TWIDDLE_WIDTH'(SAT);
    end

    logic [NLOG2-1:0] k, m, e_loc, e_nxt;
    logic [1:0]       q;

    always_comb begin
        k = ctr_i & NLOG2'(NS - 1);
        q = 2'(k >> QSH);
        m = k & NLOG2'((NS / 4) - 1);
        case (q)
            2'd0:    e_loc = '0;
            2'd1:    e_loc = m + m;
            2'd2:    e_loc = m;
            default: e_loc = m + m + m;
        endcase
        e_nxt = e_loc << (2 * STAGE);
    end

    logic [NLOG2-1:0] e_p1, ctr_p1, ctr_p2;
    logic             vld_p1, vld_p2;
    logic [1:0]       quad_p1, quad_p2;
    logic [NLOG2-3:0] r_p1;
    logic [NLOG2-2:0] idx_b;
    tw_t              ca_p2, cb_p2;

    assign quad_p1 = e_p1[NLOG2-1 -: 2];
    assign r_p1    = e_p1[NLOG2-3:0];
    assign idx_b   = (NLOG2-1)'(QN) - {1'b0, r_p1};

    tw_t re_nxt, im_nxt;

    // (cos, sin) per quadrant from a = C(r), b = C(N/4-r); output is cos - j*sin
    always_comb begin
        re_nxt = ca_p2;
        im_nxt = -cb_p2;
        case (quad_p2)
            2'd0: begin re_nxt = ca_p2;  im_nxt = -cb_p2; end
            2'd1: begin re_nxt = -cb_p2; im_nxt = -ca_p2; end
            2'd2: begin re_nxt = -ca_p2; im_nxt = cb_p2;  end
            default: begin re_nxt = cb_p2; im_nxt = ca_p2; end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            e_p1    <= '0;
            ctr_p1  <= '0;
            vld_p1  <= 1'b0;
            ca_p2   <= '0;
            cb_p2   <= '0;
            quad_p2 <= '0;
            ctr_p2  <= '0;
            vld_p2  <= 1'b0;
            w_re_o  <= '0;
            w_im_o  <= '0;
            ctr_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            e_p1    <= e_nxt;
            ctr_p1  <= ctr_i;
            vld_p1  <= valid_i;
            ca_p2   <= cos_rom[{1'b0, r_p1}];
            cb_p2   <= cos_rom[idx_b];
            quad_p2 <= quad_p1;
            ctr_p2  <= ctr_p1;
            vld_p2  <= vld_p1;
            w_re_o  <= re_nxt;
            w_im_o  <= im_nxt;
            ctr_o   <= ctr_p2;
            valid_o <= vld_p2;
        end
    end

endmodule
